// File: rtl/mmio_uart_tx.sv
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter with a small byte FIFO,
//               a data register at BASE_ADDR and a status register above it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    output logic [15:0] rdata,
    output logic        sel,
    output logic        tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]       STAT_ADDR = BASE_ADDR + 16'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    state_t            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              tx_q;

    // ------------------------------------------------------------------
    // Bus decode and FIFO handshake
    // ------------------------------------------------------------------
    logic hit_data;
    logic hit_stat;
    logic fifo_full;
    logic fifo_empty;
    logic baud_end;
    logic busy;
    logic push;
    logic push_drop;
    logic pop;
    logic ovf_clr;
    logic [7:0] fifo_head;
    logic unused_wdata_hi;

    assign hit_data   = (addr == BASE_ADDR);
    assign hit_stat   = (addr == STAT_ADDR);
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign baud_end   = (baud_q == BAUD_LAST);
    assign busy       = (state_q != ST_IDLE);
    assign fifo_head  = fifo_q[rptr_q];

    // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push.
    assign push      = we && hit_data && !fifo_full;
    assign push_drop = we && hit_data &&  fifo_full;
    assign ovf_clr   = we && hit_stat;
    assign pop       = !fifo_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_end));

    assign unused_wdata_hi = ^wdata[15:8];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= wdata[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Serial state machine, tx registered for a glitch-free line
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_head;
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                    end
                end

                ST_START: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        bit_idx_q <= 3'd0;
                        state_q   <= ST_DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

                ST_DATA: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

                ST_STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        // Back-to-back frames: reload straight into a start bit.
                        if (pop) begin
                            shift_q <= fifo_head;
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 16'h0000;
        if (hit_stat) begin
            rdata = {12'h000, ovf_q, busy, fifo_empty, fifo_full};
        end
    end

    assign sel = hit_data || hit_stat;
    assign tx  = tx_q;

endmodule

`default_nettype wire
